// File: rtl/para2ser_frame_pkg.sv
// Shared types and helpers for the parallel-to-serial frame transmitter.
// No logic; state encoding and counter sizing only.
package para2ser_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } p2s_state_e;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/para2ser_frame_if.sv
// Parallel word handshake in, serial frame stream out.
// master = word source / line observer, slave = the serialiser.
interface para2ser_frame_if #(
    parameter int unsigned WIDTH = 40
);
    logic [WIDTH-1:0] para_i;
    logic             para_valid;
    logic             para_ready;
    logic             ser_o;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output para_i, para_valid,
        input  para_ready, ser_o, ser_valid, frame_start, frame_end, busy
    );

    modport slave (
        input  para_i, para_valid,
        output para_ready, ser_o, ser_valid, frame_start, frame_end, busy
    );
endinterface

// File: rtl/para2ser_frame_bit_tick_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled, tick on the last count.
// Latency: tick is combinational from the count; clr wins over en; no backpressure.
module para2ser_frame_bit_tick_gen #(
    parameter int unsigned DIV   = 10000,
    parameter int unsigned CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/para2ser_frame.sv
// Parallel-to-serial framer: optional sync header then WIDTH payload bits, DIV clks/bit.
// Latency: first bit on ser_o the clk after the transfer edge; ready only in IDLE or on the last bit tick.
module para2ser_frame
    import para2ser_frame_pkg::*;
#(
    parameter int unsigned WIDTH     = 40,
    parameter int unsigned DIV       = 10000,
    parameter int unsigned CNT_W     = 14,
    parameter int unsigned SYNC_LEN  = 8,
    parameter logic [((SYNC_LEN > 0) ? SYNC_LEN : 1)-1:0] SYNC_WORD = 8'hA5,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_LVL  = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    para2ser_frame_if.slave bus
);

    localparam int unsigned SW   = (SYNC_LEN > 0) ? SYNC_LEN : 1;
    localparam int unsigned BC_W = cnt_width((WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN);
    localparam logic [BC_W-1:0] LAST_DATA = BC_W'(WIDTH - 1);
    localparam logic [BC_W-1:0] LAST_SYNC = (SYNC_LEN > 0) ? BC_W'(SYNC_LEN - 1) : '0;
    localparam p2s_state_e FIRST_ST = (SYNC_LEN > 0) ? ST_SYNC : ST_DATA;

    p2s_state_e       state;
    p2s_state_e       state_nxt;
    logic [CNT_W-1:0] div_cnt;
    logic             tick;
    logic             run_en;
    logic             cnt_clr;
    logic [BC_W-1:0]  bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [SW-1:0]    sync_sreg;
    logic [SW-1:0]    sync_nxt;
    logic             ser_q;
    logic             ser_nxt;
    logic             xfer;
    logic             sync_done;
    logic             data_done;
    logic             rdy;
    logic             active;
    logic             fstart;
    logic             fend;

    assign sync_done = (state == ST_SYNC) && tick && (bit_cnt == LAST_SYNC);
    assign data_done = (state == ST_DATA) && tick && (bit_cnt == LAST_DATA);
    assign xfer      = bus.para_valid && rdy;
    assign run_en    = (state != ST_IDLE);
    // A back-to-back transfer keeps the state but must still restart the bit timing.
    assign cnt_clr   = xfer || (state_nxt != state);

    para2ser_frame_bit_tick_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_en),
        .clr   (cnt_clr),
        .tick  (tick),
        .cnt   (div_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (xfer) state_nxt = FIRST_ST;
            ST_SYNC: if (sync_done) state_nxt = ST_DATA;
            ST_DATA: if (data_done) state_nxt = xfer ? FIRST_ST : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rdy    = (state == ST_IDLE) || data_done;
        active = (state != ST_IDLE);
        fstart = (state == FIRST_ST) && (bit_cnt == '0) && (div_cnt == '0);
        fend   = data_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
        end else if (tick) begin
            bit_cnt <= bit_cnt + BC_W'(1);
        end
    end

    // The register holds the bit on the line at its top (or bottom) end; the
    // next line value is taken from the post-update register so ser_o stays registered.
    always_comb begin
        sreg_nxt = sreg;
        sync_nxt = sync_sreg;
        if (xfer) begin
            sreg_nxt = bus.para_i;
            sync_nxt = SYNC_WORD;
        end else if (tick) begin
            if (state == ST_SYNC) begin
                sync_nxt = sync_sreg << 1;
            end
            if (state == ST_DATA) begin
                sreg_nxt = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            end
        end

        case (state_nxt)
            ST_SYNC: ser_nxt = sync_nxt[SW-1];
            ST_DATA: ser_nxt = MSB_FIRST ? sreg_nxt[WIDTH-1] : sreg_nxt[0];
            default: ser_nxt = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            sync_sreg <= '0;
            ser_q     <= IDLE_LVL;
        end else begin
            sreg      <= sreg_nxt;
            sync_sreg <= sync_nxt;
            ser_q     <= ser_nxt;
        end
    end

    assign bus.para_ready  = rdy;
    assign bus.ser_o       = ser_q;
    assign bus.ser_valid   = active;
    assign bus.busy        = active;
    assign bus.frame_start = fstart;
    assign bus.frame_end   = fend;

endmodule

// File: tb/tb_para2ser_frame.sv
// Directed bench for para2ser_frame: four parameter sets sharing one clock and reset.
module tb_para2ser_frame;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int sel = 0;

    para2ser_frame_if #(.WIDTH(40)) a_if ();
    para2ser_frame_if #(.WIDTH(40)) b_if ();
    para2ser_frame_if #(.WIDTH(40)) c_if ();
    para2ser_frame_if #(.WIDTH(1))  d_if ();

    para2ser_frame #(.WIDTH(40), .DIV(4), .CNT_W(2), .SYNC_LEN(0), .SYNC_WORD(1'b0),
                     .MSB_FIRST(1'b1), .IDLE_LVL(1'b0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    para2ser_frame #(.WIDTH(40), .DIV(4), .CNT_W(2), .SYNC_LEN(8), .SYNC_WORD(8'hA5),
                     .MSB_FIRST(1'b1), .IDLE_LVL(1'b0))
        u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    para2ser_frame #(.WIDTH(40), .DIV(4), .CNT_W(2), .SYNC_LEN(0), .SYNC_WORD(1'b0),
                     .MSB_FIRST(1'b0), .IDLE_LVL(1'b0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));
    para2ser_frame #(.WIDTH(1), .DIV(2), .CNT_W(1), .SYNC_LEN(0), .SYNC_WORD(1'b0),
                     .MSB_FIRST(1'b1), .IDLE_LVL(1'b1))
        u_d (.clk(clk), .rst_n(rst_n), .bus(d_if));

    logic m_ser, m_sv, m_fs, m_fe, m_rdy, m_busy;
    always_comb begin
        case (sel)
            1: {m_ser, m_sv, m_fs, m_fe, m_rdy, m_busy} =
               {b_if.ser_o, b_if.ser_valid, b_if.frame_start, b_if.frame_end, b_if.para_ready, b_if.busy};
            2: {m_ser, m_sv, m_fs, m_fe, m_rdy, m_busy} =
               {c_if.ser_o, c_if.ser_valid, c_if.frame_start, c_if.frame_end, c_if.para_ready, c_if.busy};
            default: {m_ser, m_sv, m_fs, m_fe, m_rdy, m_busy} =
               {a_if.ser_o, a_if.ser_valid, a_if.frame_start, a_if.frame_end, a_if.para_ready, a_if.busy};
        endcase
    end

    logic ser_h [0:399];
    logic sv_h  [0:399];
    logic fs_h  [0:399];
    logic fe_h  [0:399];
    logic rdy_h [0:399];

    // Record n consecutive clks of the selected DUT, sampled 1 time unit after each edge.
    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            ser_h[c] = m_ser; sv_h[c] = m_sv; fs_h[c] = m_fs; fe_h[c] = m_fe; rdy_h[c] = m_rdy;
            @(posedge clk); #1;
        end
    endtask

    // Reduce a recorded frame window to the bit stream (first bit at the top) and event stats.
    task automatic analyze(input int nbits, input int div, output logic [47:0] stream,
                           output int hold_err, output int fs_first, output int fs_n,
                           output int fe_last, output int fe_n, output int sv_n, output int rdy_n);
        stream = '0; hold_err = 0; fs_first = -1; fs_n = 0; fe_last = -1; fe_n = 0; sv_n = 0; rdy_n = 0;
        for (int c = 0; c < nbits * div; c++) begin
            if (c % div == 0) stream[nbits - 1 - c / div] = ser_h[c];
            else if (ser_h[c] !== ser_h[c - (c % div)]) hold_err++;
            if (fs_h[c] === 1'b1) begin if (fs_first < 0) fs_first = c; fs_n++; end
            if (fe_h[c] === 1'b1) begin fe_last = c; fe_n++; end
            if (sv_h[c] === 1'b1) sv_n++;
            if (rdy_h[c] === 1'b1) rdy_n++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({a_if.ser_o, a_if.ser_valid, a_if.frame_start, a_if.frame_end, a_if.busy, a_if.para_ready} !== 6'b000001) begin
            n_err++;
            $display("FAIL reset_outputs_a: got %b want 000001",
                     {a_if.ser_o, a_if.ser_valid, a_if.frame_start, a_if.frame_end, a_if.busy, a_if.para_ready});
        end
        n_cmp++;
        if ({d_if.ser_o, d_if.ser_valid, d_if.para_ready} !== 3'b101) begin
            n_err++;
            $display("FAIL reset_outputs_d: got %b want 101", {d_if.ser_o, d_if.ser_valid, d_if.para_ready});
        end
        #8 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_msb_nosync();
        logic [47:0] s; int he, fsf, fsn, fel, fen, svn, rdn;
        sel = 0;
        a_if.para_i = 40'hF00FAA55C3; a_if.para_valid = 1'b1;
        n_cmp++;
        if (a_if.para_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", a_if.para_ready); end
        @(posedge clk); #1;
        a_if.para_valid = 1'b0; a_if.para_i = '0;
        n_cmp++;
        if (m_busy !== 1'b1) begin n_err++; $display("FAIL msb_busy_first: got %b want 1", m_busy); end
        capture(162);
        analyze(40, 4, s, he, fsf, fsn, fel, fen, svn, rdn);
        n_cmp++;
        if (s[39:0] !== 40'hF00FAA55C3) begin n_err++; $display("FAIL msb_stream: got %h want f00faa55c3", s[39:0]); end
        n_cmp++;
        if (he !== 0) begin n_err++; $display("FAIL msb_hold: got %0d unstable clks want 0", he); end
        n_cmp++;
        if (fsf !== 0 || fsn !== 1) begin n_err++; $display("FAIL msb_frame_start: got idx %0d cnt %0d want idx 0 cnt 1", fsf, fsn); end
        n_cmp++;
        if (fel !== 159 || fen !== 1) begin n_err++; $display("FAIL msb_frame_end: got idx %0d cnt %0d want idx 159 cnt 1", fel, fen); end
        n_cmp++;
        if (svn !== 160 || rdn !== 1) begin n_err++; $display("FAIL msb_valid_ready: got sv %0d rdy %0d want 160 1", svn, rdn); end
        n_cmp++;
        if ({sv_h[160], ser_h[160], m_busy} !== 3'b000) begin
            n_err++; $display("FAIL msb_idle_after: got %b want 000", {sv_h[160], ser_h[160], m_busy});
        end
    endtask

    task automatic test_sync_header();
        logic [47:0] s; int he, fsf, fsn, fel, fen, svn, rdn;
        sel = 1;
        b_if.para_i = 40'h123456789A; b_if.para_valid = 1'b1;
        @(posedge clk); #1;
        b_if.para_valid = 1'b0;
        capture(194);
        analyze(48, 4, s, he, fsf, fsn, fel, fen, svn, rdn);
        n_cmp++;
        if (s !== 48'hA5123456789A) begin n_err++; $display("FAIL sync_stream: got %h want a5123456789a", s); end
        n_cmp++;
        if (fsf !== 0 || fsn !== 1) begin n_err++; $display("FAIL sync_frame_start: got idx %0d cnt %0d want idx 0 cnt 1", fsf, fsn); end
        n_cmp++;
        if (fel !== 191 || fen !== 1) begin n_err++; $display("FAIL sync_frame_end: got idx %0d cnt %0d want idx 191 cnt 1", fel, fen); end
        n_cmp++;
        if (svn !== 192 || he !== 0 || sv_h[192] !== 1'b0) begin
            n_err++; $display("FAIL sync_valid: got sv %0d hold %0d after %b want 192 0 0", svn, he, sv_h[192]);
        end
    endtask

    task automatic test_lsb_first();
        logic [47:0] s; int he, fsf, fsn, fel, fen, svn, rdn;
        sel = 2;
        c_if.para_i = 40'h1; c_if.para_valid = 1'b1;
        @(posedge clk); #1;
        c_if.para_valid = 1'b0;
        capture(162);
        analyze(40, 4, s, he, fsf, fsn, fel, fen, svn, rdn);
        n_cmp++;
        if (s[39:0] !== 40'h8000000000) begin n_err++; $display("FAIL lsb_one: got %h want 8000000000", s[39:0]); end
        n_cmp++;
        if (fsf !== 0 || fel !== 159) begin n_err++; $display("FAIL lsb_bounds: got fs %0d fe %0d want 0 159", fsf, fel); end
        c_if.para_i = 40'hF00FAA55C3; c_if.para_valid = 1'b1;
        @(posedge clk); #1;
        c_if.para_valid = 1'b0;
        capture(162);
        analyze(40, 4, s, he, fsf, fsn, fel, fen, svn, rdn);
        n_cmp++;
        if (s[39:0] !== 40'hC3AA55F00F) begin n_err++; $display("FAIL lsb_pattern: got %h want c3aa55f00f", s[39:0]); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] s; int he, fsf, fsn, fel, fen, svn, rdn;
        sel = 0;
        a_if.para_i = 40'h0F0F00FFAB; a_if.para_valid = 1'b1;
        @(posedge clk); #1;
        a_if.para_i = 40'h5A5A3C3C81;
        capture(159);
        n_cmp++;
        if ({m_rdy, m_fe, m_fs} !== 3'b110) begin
            n_err++; $display("FAIL b2b_last_tick: got rdy/fe/fs %b want 110", {m_rdy, m_fe, m_fs});
        end
        ser_h[159] = m_ser; sv_h[159] = m_sv; fs_h[159] = m_fs; fe_h[159] = m_fe; rdy_h[159] = m_rdy;
        @(posedge clk); #1;
        a_if.para_valid = 1'b0;
        analyze(40, 4, s, he, fsf, fsn, fel, fen, svn, rdn);
        n_cmp++;
        if (s[39:0] !== 40'h0F0F00FFAB) begin n_err++; $display("FAIL b2b_first_stream: got %h want 0f0f00ffab", s[39:0]); end
        n_cmp++;
        if (rdn !== 1 || svn !== 160) begin n_err++; $display("FAIL b2b_first_ready: got rdy %0d sv %0d want 1 160", rdn, svn); end
        capture(162);
        analyze(40, 4, s, he, fsf, fsn, fel, fen, svn, rdn);
        n_cmp++;
        if (fsf !== 0) begin n_err++; $display("FAIL b2b_no_gap: got frame_start idx %0d want 0", fsf); end
        n_cmp++;
        if (s[39:0] !== 40'h5A5A3C3C81) begin n_err++; $display("FAIL b2b_second_stream: got %h want 5a5a3c3c81", s[39:0]); end
        n_cmp++;
        if (fel !== 159 || rdn !== 1 || sv_h[160] !== 1'b0) begin
            n_err++; $display("FAIL b2b_second_end: got fe %0d rdy %0d sv_after %b want 159 1 0", fel, rdn, sv_h[160]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [47:0] s; int he, fsf, fsn, fel, fen, svn, rdn;
        sel = 0;
        a_if.para_i = 40'hFFFFFFFFFF; a_if.para_valid = 1'b1;
        @(posedge clk); #1;
        a_if.para_valid = 1'b0;
        capture(81);
        n_cmp++;
        if ({m_ser, m_sv} !== 2'b11) begin n_err++; $display("FAIL pre_reset_bit20: got %b want 11", {m_ser, m_sv}); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_ser, m_sv, m_fs, m_fe, m_busy, m_rdy} !== 6'b000001) begin
            n_err++; $display("FAIL midframe_reset: got %b want 000001", {m_ser, m_sv, m_fs, m_fe, m_busy, m_rdy});
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        a_if.para_i = 40'h0123456789; a_if.para_valid = 1'b1;
        @(posedge clk); #1;
        a_if.para_valid = 1'b0;
        capture(162);
        analyze(40, 4, s, he, fsf, fsn, fel, fen, svn, rdn);
        n_cmp++;
        if (s[39:0] !== 40'h0123456789 || fsf !== 0 || fel !== 159 || svn !== 160) begin
            n_err++;
            $display("FAIL fresh_frame: got %h fs %0d fe %0d sv %0d want 0123456789 0 159 160", s[39:0], fsf, fel, svn);
        end
    endtask

    task automatic test_div2_width1();
        logic [3:0] seq;
        logic [9:0] ser_v, sv_v, fs_v, fe_v;
        logic acc;
        int i;
        seq = 4'b1001;
        i = 0;
        d_if.para_i = seq[0]; d_if.para_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            acc = d_if.para_ready & d_if.para_valid;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                if (i < 4) d_if.para_i = seq[i];
                else d_if.para_valid = 1'b0;
            end
            ser_v[c] = d_if.ser_o; sv_v[c] = d_if.ser_valid; fs_v[c] = d_if.frame_start; fe_v[c] = d_if.frame_end;
        end
        n_cmp++;
        if (ser_v !== 10'b1111000011) begin n_err++; $display("FAIL w1_ser: got %b want 1111000011", ser_v); end
        n_cmp++;
        if (sv_v !== 10'b0011111111) begin n_err++; $display("FAIL w1_valid: got %b want 0011111111", sv_v); end
        n_cmp++;
        if (fs_v !== 10'b0001010101) begin n_err++; $display("FAIL w1_frame_start: got %b want 0001010101", fs_v); end
        n_cmp++;
        if (fe_v !== 10'b0010101010) begin n_err++; $display("FAIL w1_frame_end: got %b want 0010101010", fe_v); end
        n_cmp++;
        if (i !== 4) begin n_err++; $display("FAIL w1_accepted: got %0d want 4", i); end
    endtask

    initial begin
        a_if.para_i = '0; a_if.para_valid = 1'b0;
        b_if.para_i = '0; b_if.para_valid = 1'b0;
        c_if.para_i = '0; c_if.para_valid = 1'b0;
        d_if.para_i = '0; d_if.para_valid = 1'b0;
        test_reset();
        test_msb_nosync();
        test_sync_header();
        test_lsb_first();
        test_back_to_back();
        test_reset_mid_frame();
        test_div2_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
